// File: rtl/regfile_sb_pkg.sv
// regfile_sb_pkg: shared defaults, depth helper and packed-port slice macro
// for the scoreboarded register file.
`ifndef REGFILE_SB_PKG_SV
`define REGFILE_SB_PKG_SV

// Selects lane idx of width w from a packed multi-port vector.
`define RF_SLICE(idx, w) (idx)*(w) +: (w)

package regfile_sb_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 5;
    localparam int NRD_DEF      = 2;
    localparam int ZERO_REG_DEF = 1;

    // Number of architectural registers for a given address width.
    function automatic int depthOf(input int addrW);
        return 1 << addrW;
    endfunction

endpackage

`endif

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: write, issue and read bus of the scoreboarded register file.
// The master (decode/writeback side) drives requests; the slave answers reads.
interface regfile_sb_if
    import regfile_sb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NRD    = NRD_DEF
);
    logic                    we;
    logic [ADDR_W-1:0]       wa;
    logic [DATA_W-1:0]       wd;
    logic                    iss_v;
    logic [ADDR_W-1:0]       iss_a;
    logic [NRD*ADDR_W-1:0]   ra;
    logic [NRD*DATA_W-1:0]   rd;
    logic [NRD-1:0]          rbusy;
    logic                    busy_any;

    modport master (
        output we, wa, wd, iss_v, iss_a, ra,
        input  rd, rbusy, busy_any
    );

    modport slave (
        input  we, wa, wd, iss_v, iss_a, ra,
        output rd, rbusy, busy_any
    );

endinterface

// File: rtl/regfile_sb_rdport.sv
// regfile_sb_rdport: one combinational read port of the register file.
// Handles the hardwired-zero register, the busy-bit lookup and, when
// REGFILE_BYPASS_EN is defined, forwarding of the write in flight.
module regfile_sb_rdport
    import regfile_sb_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DEPTH    = depthOf(ADDR_W_DEF),
    parameter int ZERO_REG = ZERO_REG_DEF
) (
    input  logic [ADDR_W-1:0] i_ra,
    input  logic [DATA_W-1:0] i_rf [DEPTH],
    input  logic [DEPTH-1:0]  i_busy,
`ifdef REGFILE_BYPASS_EN
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_wa,
    input  logic [DATA_W-1:0] i_wd,
    input  logic              i_issV,
    input  logic [ADDR_W-1:0] i_issA,
`endif
    output logic [DATA_W-1:0] o_rd,
    output logic              o_rbusy
);

    logic w_isZero;

    // Stored value and busy bit, overridden for register 0 and (optionally) a same-cycle write.
    always_comb begin
        w_isZero = (ZERO_REG != 0) && (i_ra == '0);
        o_rd     = i_rf[i_ra];
        o_rbusy  = i_busy[i_ra];
        if (w_isZero) begin
            o_rd    = '0;
            o_rbusy = 1'b0;
        end
`ifdef REGFILE_BYPASS_EN
        else if (i_we && (i_wa == i_ra)) begin
            o_rd    = i_wd;
            o_rbusy = i_issV && (i_issA == i_ra);
        end
`endif
    end

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with NRD combinational read ports,
// one synchronous write port and a per-register pending-write scoreboard.
// Optional macro REGFILE_BYPASS_EN forwards the current write to readers.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NRD      = NRD_DEF,
    parameter int ZERO_REG = ZERO_REG_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    regfile_sb_if.slave bus
);

    localparam int DEPTH = depthOf(ADDR_W);

    logic [DATA_W-1:0] r_rf [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic              w_wrEn;
    logic [DATA_W-1:0] w_rd [NRD];
    logic [NRD-1:0]    w_rbusy;

    // Drop writes aimed at the hardwired zero register.
    always_comb begin
        w_wrEn = bus.we;
        if ((ZERO_REG != 0) && (bus.wa == '0)) begin
            w_wrEn = 1'b0;
        end
    end

    // Register storage, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < DEPTH; r++) begin
                r_rf[r] <= '0;
            end
        end else if (w_wrEn) begin
            r_rf[bus.wa] <= bus.wd;
        end
    end

    // Scoreboard: issue sets, write clears, issue wins when both hit one register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy <= '0;
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                if ((ZERO_REG != 0) && (r == 0)) begin
                    r_busy[r] <= 1'b0;
                end else if (bus.iss_v && (bus.iss_a == ADDR_W'(r))) begin
                    r_busy[r] <= 1'b1;
                end else if (bus.we && (bus.wa == ADDR_W'(r))) begin
                    r_busy[r] <= 1'b0;
                end
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic w_bypWe;

    // Forwarding is suppressed while in reset so reads stay zero.
    always_comb begin
        w_bypWe = bus.we & reset_n;
    end
`endif

    for (genvar g = 0; g < NRD; g++) begin : g_rdport
        regfile_sb_rdport #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .DEPTH    (DEPTH),
            .ZERO_REG (ZERO_REG)
        ) u_rdport (
            .i_ra    (bus.ra[`RF_SLICE(g, ADDR_W)]),
            .i_rf    (r_rf),
            .i_busy  (r_busy),
`ifdef REGFILE_BYPASS_EN
            .i_we    (w_bypWe),
            .i_wa    (bus.wa),
            .i_wd    (bus.wd),
            .i_issV  (bus.iss_v),
            .i_issA  (bus.iss_a),
`endif
            .o_rd    (w_rd[g]),
            .o_rbusy (w_rbusy[g])
        );
    end

    // Pack the per-port results onto the bus.
    always_comb begin
        bus.rd = '0;
        for (int p = 0; p < NRD; p++) begin
            bus.rd[`RF_SLICE(p, DATA_W)] = w_rd[p];
        end
        bus.rbusy    = w_rbusy;
        bus.busy_any = |r_busy;
    end

endmodule
